// File: rtl/retospect_bs_loader_if.sv
// retospect_bs_loader_if: host byte port and readback strobe for the bitstream loader
interface retospect_bs_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  modport master (output byte_data, byte_valid, input byte_ready, rd_data, rd_valid);
  modport slave (input byte_data, byte_valid, output byte_ready, rd_data, rd_valid);
endinterface

// File: rtl/retospect_bs_loader.sv
// retospect_bs_loader: serializes host bytes LSB-first into the config chain and returns readback
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 523,
  parameter int CNT_W     = 10,
  parameter bit ARM_NN    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  retospect_bs_loader_if.slave   bus,
  output logic                   config_en,
  output logic                   cfg_bs,
  input  logic                   cfg_bs_ret,
  output logic                   reset_nn,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);
  localparam int NB = (CHAIN_LEN + 7) / 8;
  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, ARM, DONE} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_hold, r_sreg, r_rb, r_rd_data, w_rb;
  logic             r_hold_valid, r_rd_valid, r_underrun;
  logic [2:0]       r_bit_idx;
  logic [CNT_W-1:0] r_total, r_nbytes;
  logic             w_last, w_bound, w_load, w_accept, w_start;
  assign w_start  = r_state == IDLE && start;
  assign w_last   = r_state == SHIFT && r_total == CNT_W'(CHAIN_LEN - 1);
  assign w_bound  = r_state == SHIFT && r_bit_idx == 3'd7 && !w_last;
  assign w_load   = (r_state == WAIT || w_bound) && r_hold_valid;
  assign w_accept = bus.byte_valid && bus.byte_ready;
  // bits above the current position are masked so a partial final byte reads back with zero upper bits
  assign w_rb = (r_rb & ((8'd1 << r_bit_idx) - 8'd1)) | (8'(cfg_bs_ret) << r_bit_idx);
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? WAIT : IDLE;
      WAIT:    w_next = r_hold_valid ? SHIFT : WAIT;
      SHIFT:   w_next = w_last ? (ARM_NN ? ARM : DONE) : (w_bound && !r_hold_valid) ? IDLE : SHIFT;
      ARM:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.byte_ready = (r_state == WAIT || r_state == SHIFT) && !r_hold_valid && r_nbytes < CNT_W'(NB);
    config_en      = r_state == SHIFT;
    cfg_bs         = r_state == SHIFT && r_sreg[0];
    reset_nn       = r_state == ARM;
    busy           = r_state != IDLE;
    done           = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_sreg       <= '0;
      r_rb         <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_underrun   <= 1'b0;
      r_bit_idx    <= '0;
      r_total      <= '0;
      r_nbytes     <= '0;
    end else begin
      r_rd_valid   <= w_last || w_bound;
      r_hold_valid <= w_accept || (r_hold_valid && !w_load && !w_start);
      if (w_last || w_bound) r_rd_data <= w_rb;
      if (w_start) begin
        r_total    <= '0;
        r_nbytes   <= '0;
        r_underrun <= 1'b0;
      end
      if (w_accept) begin
        r_hold   <= bus.byte_data;
        r_nbytes <= r_nbytes + CNT_W'(1);
      end
      if (r_state == SHIFT) begin
        r_sreg    <= r_sreg >> 1;
        r_rb      <= w_rb;
        r_bit_idx <= r_bit_idx + 3'd1;
        r_total   <= r_total + CNT_W'(1);
      end
      if (w_load) begin
        r_sreg    <= r_hold;
        r_bit_idx <= '0;
      end
      if (w_bound && !r_hold_valid) r_underrun <= 1'b1;
    end
  end
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign underrun     = r_underrun;
endmodule
